// File: rtl/segment_ex_if.sv
// -----------------------------------------------------------------------------
// segment_ex_if
// Bundles the ID/EX -> EX -> EX/MEM signals of the execute stage.
//   master : upstream/downstream environment (drives ID/EX fields and flush,
//            observes EX/MEM fields and stall)
//   slave  : the execute stage itself
// Signals:
//   flush                       kill the instruction currently in EX
//   MemToReg/MemRead/MemWrite/RegWrite_in, ALUSrc_in, ALUOp_in, pc_in,
//   RD1/RD2/RD3_in, RR3_in, num_in        ID/EX register outputs
//   MemToReg/MemRead/MemWrite/RegWrite_out, ALUResult_out, WriteData_out,
//   RR3_out, pc_out, zero_out             registered EX/MEM fields
//   stall                       hold ID/EX and earlier stages
// -----------------------------------------------------------------------------
interface segment_ex_if #(
  parameter int DATA_WIDTH     = 21,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      flush;
  logic                      MemToReg_in;
  logic                      MemRead_in;
  logic                      MemWrite_in;
  logic                      RegWrite_in;
  logic                      ALUSrc_in;
  logic [2:0]                ALUOp_in;
  logic [DATA_WIDTH-1:0]     pc_in;
  logic [DATA_WIDTH-1:0]     RD1_in;
  logic [DATA_WIDTH-1:0]     RD2_in;
  logic [DATA_WIDTH-1:0]     RD3_in;
  logic [REG_ADDR_WIDTH-1:0] RR3_in;
  logic [DATA_WIDTH-1:0]     num_in;

  logic                      MemToReg_out;
  logic                      MemRead_out;
  logic                      MemWrite_out;
  logic                      RegWrite_out;
  logic [DATA_WIDTH-1:0]     ALUResult_out;
  logic [DATA_WIDTH-1:0]     WriteData_out;
  logic [REG_ADDR_WIDTH-1:0] RR3_out;
  logic [DATA_WIDTH-1:0]     pc_out;
  logic                      zero_out;
  logic                      stall;

  modport master (
    output flush, MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in,
           ALUSrc_in, ALUOp_in, pc_in, RD1_in, RD2_in, RD3_in, RR3_in, num_in,
    input  MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out,
           ALUResult_out, WriteData_out, RR3_out, pc_out, zero_out, stall
  );

  modport slave (
    input  flush, MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in,
           ALUSrc_in, ALUOp_in, pc_in, RD1_in, RD2_in, RD3_in, RR3_in, num_in,
    output MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out,
           ALUResult_out, WriteData_out, RR3_out, pc_out, zero_out, stall
  );
endinterface

// File: rtl/segment_ex.sv
// -----------------------------------------------------------------------------
// segment_ex
// Execute stage: selects operand B, runs the ALU and registers the result with
// the surviving control bits toward EX/MEM. MUL uses an iterative shift-add
// multiplier; while it runs, stall holds the upstream stages and bubbles are
// sent downstream.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (priority over flush and operations)
//   ex   segment_ex_if.slave bundle (ID/EX inputs, flush, EX/MEM outputs, stall)
// -----------------------------------------------------------------------------
module segment_ex #(
  parameter int DATA_WIDTH     = 21,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MUL_CYCLES     = DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  segment_ex_if.slave ex
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  // Fields registered toward EX/MEM; the all-zero value is a bubble.
  typedef struct packed {
    logic                      mem_to_reg;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [REG_ADDR_WIDTH-1:0] rr3;
    logic [DATA_WIDTH-1:0]     pc;
    logic                      zero;
  } ex_mem_t;

  // Pass-through fields of a MUL, captured when it starts.
  typedef struct packed {
    logic                      mem_to_reg;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [REG_ADDR_WIDTH-1:0] rr3;
    logic [DATA_WIDTH-1:0]     pc;
  } held_t;

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t                state, state_nxt;
  ex_mem_t               out_q, out_d;
  held_t                 held;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] a_shift, b_shift, acc;
  logic [CNT_W-1:0]      cnt;
  logic                  start_mul;
  logic                  stall;

  // Operand select and single-cycle ALU.
  // NOTE: every signal assigned in an always_comb gets a default at the top so no latch is inferred.
  always_comb begin
    op_b  = ex.ALUSrc_in ? ex.num_in : ex.RD2_in;
    shamt = op_b[4:0];
    alu_y = '0;
    case (alu_op_t'(ex.ALUOp_in))
      OP_ADD: alu_y = ex.RD1_in + op_b;
      OP_SUB: alu_y = ex.RD1_in - op_b;
      OP_AND: alu_y = ex.RD1_in & op_b;
      OP_OR:  alu_y = ex.RD1_in | op_b;
      OP_XOR: alu_y = ex.RD1_in ^ op_b;
      OP_MUL: alu_y = '0;  // produced by the iterative unit instead
      OP_SLL: alu_y = (int'(shamt) < DATA_WIDTH) ? (ex.RD1_in << shamt) : '0;
      OP_SRL: alu_y = (int'(shamt) < DATA_WIDTH) ? (ex.RD1_in >> shamt) : '0;
      default: alu_y = '0;
    endcase
  end

  // Next-state, stall and next EX/MEM contents.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start_mul = 1'b0;
    out_d     = '0;
    case (state)
      S_IDLE: begin
        if (ex.ALUOp_in == OP_MUL) begin
          // Reset wins, so the upstream is not held during a reset edge.
          stall     = !rst;
          start_mul = 1'b1;
          state_nxt = S_MUL;
        end else begin
          out_d.mem_to_reg = ex.MemToReg_in;
          out_d.mem_read   = ex.MemRead_in;
          out_d.mem_write  = ex.MemWrite_in;
          out_d.reg_write  = ex.RegWrite_in;
          out_d.alu_result = alu_y;
          out_d.write_data = ex.RD3_in;
          out_d.rr3        = ex.RR3_in;
          out_d.pc         = ex.pc_in;
          out_d.zero       = (alu_y == '0);
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        // The MUL is still held upstream; the live ALUOp is not looked at.
        out_d.mem_to_reg = held.mem_to_reg;
        out_d.mem_read   = held.mem_read;
        out_d.mem_write  = held.mem_write;
        out_d.reg_write  = held.reg_write;
        out_d.alu_result = acc;
        out_d.write_data = held.write_data;
        out_d.rr3        = held.rr3;
        out_d.pc         = held.pc;
        out_d.zero       = (acc == '0);
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (ex.flush) begin
      out_d     = '0;
      state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      out_q <= out_d;
    end
  end

  // NOTE: the multiplier datapath and held fields carry no reset; they are always loaded before the FSM reads them.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start_mul) begin
      a_shift         <= ex.RD1_in;
      b_shift         <= op_b;
      acc             <= '0;
      cnt             <= '0;
      held.mem_to_reg <= ex.MemToReg_in;
      held.mem_read   <= ex.MemRead_in;
      held.mem_write  <= ex.MemWrite_in;
      held.reg_write  <= ex.RegWrite_in;
      held.write_data <= ex.RD3_in;
      held.rr3        <= ex.RR3_in;
      held.pc         <= ex.pc_in;
    end else if (state == S_MUL) begin
      if (b_shift[0]) acc <= acc + a_shift;
      a_shift <= a_shift << 1;
      b_shift <= b_shift >> 1;
      cnt     <= cnt + 1'b1;
    end
  end

  assign ex.MemToReg_out  = out_q.mem_to_reg;
  assign ex.MemRead_out   = out_q.mem_read;
  assign ex.MemWrite_out  = out_q.mem_write;
  assign ex.RegWrite_out  = out_q.reg_write;
  assign ex.ALUResult_out = out_q.alu_result;
  assign ex.WriteData_out = out_q.write_data;
  assign ex.RR3_out       = out_q.rr3;
  assign ex.pc_out        = out_q.pc;
  assign ex.zero_out      = out_q.zero;
  assign ex.stall         = stall;

endmodule

// File: tb/tb_segment_ex.sv
// -----------------------------------------------------------------------------
// tb_segment_ex
// Drives instructions into segment_ex the way a stalled ID/EX register would,
// pushes the expected per-cycle stall and EX/MEM contents into a scoreboard,
// and lets an independent monitor compare them against the DUT.
// -----------------------------------------------------------------------------
module tb_segment_ex;
  localparam int DW   = 21;
  localparam int RW   = 4;
  localparam int MASK = (1 << DW) - 1;
  localparam int OP_MUL = 5;
  localparam int MUL_LEN = 23;   // cycles a MUL occupies the inputs

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segment_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) bus ();

  segment_ex #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .MUL_CYCLES(DW)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  typedef struct {
    bit m2r, mrd, mwr, rw, src;
    int op, pc, rd1, rd2, rd3, num, rr3;
  } instr_t;

  typedef struct {
    bit stall;
    bit m2r, mrd, mwr, rw, zero;
    int res, wd, rr3, pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the instruction-set rules, in plain integer arithmetic.
  function automatic int alu_model(input instr_t t);
    longint a  = longint'(t.rd1);
    longint b  = longint'(t.src ? t.num : t.rd2);
    longint m  = longint'(MASK);
    int     sh = int'(b % 32);
    case (t.op)
      0: return int'((a + b) & m);
      1: return int'((a - b) & m);
      2: return int'(a & b);
      3: return int'(a | b);
      4: return int'(a ^ b);
      5: return int'((a * b) % (longint'(1) << DW));
      6: return (sh >= DW) ? 0 : int'((a << sh) & m);
      default: return (sh >= DW) ? 0 : int'(a >> sh);
    endcase
  endfunction

  function automatic exp_t bubble(input bit st);
    exp_t e = '{default: 0};
    e.stall = st;
    return e;
  endfunction

  function automatic exp_t result_of(input instr_t t, input int forced, input bit st);
    exp_t e;
    e.stall = st;
    e.m2r = t.m2r; e.mrd = t.mrd; e.mwr = t.mwr; e.rw = t.rw;
    e.res  = (forced >= 0) ? forced : alu_model(t);
    e.zero = (e.res == 0);
    e.wd = t.rd3; e.rr3 = t.rr3; e.pc = t.pc;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.m2r = 1'($urandom); t.mrd = 1'($urandom); t.mwr = 1'($urandom);
    t.rw  = 1'($urandom); t.src = 1'($urandom);
    t.op  = int'($urandom_range(0, 7));
    t.pc  = int'($urandom) & MASK;
    t.rd1 = int'($urandom) & MASK;
    t.rd2 = ($urandom_range(0, 7) == 0) ? t.rd1 : int'($urandom) & MASK;
    t.rd3 = int'($urandom) & MASK;
    t.num = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom) & MASK;
    t.rr3 = int'($urandom_range(0, 15));
    return t;
  endfunction

  function automatic instr_t mk(input int op, input int rd1, input int rd2, input int num,
                                input bit src, input bit rw, input int rr3);
    instr_t t = rand_instr();
    t.op = op; t.rd1 = rd1; t.rd2 = rd2; t.num = num; t.src = src; t.rw = rw; t.rr3 = rr3;
    return t;
  endfunction

  task automatic drive(input instr_t t, input bit fl, input bit rs);
    bus.MemToReg_in = t.m2r;
    bus.MemRead_in  = t.mrd;
    bus.MemWrite_in = t.mwr;
    bus.RegWrite_in = t.rw;
    bus.ALUSrc_in   = t.src;
    bus.ALUOp_in    = 3'(t.op);
    bus.pc_in       = DW'(t.pc);
    bus.RD1_in      = DW'(t.rd1);
    bus.RD2_in      = DW'(t.rd2);
    bus.RD3_in      = DW'(t.rd3);
    bus.num_in      = DW'(t.num);
    bus.RR3_in      = RW'(t.rr3);
    bus.flush       = fl;
    rst             = rs;
  endtask

  // One clock: apply inputs, record what this cycle must show, advance.
  task automatic cycle(input instr_t t, input bit fl, input bit rs, input exp_t e);
    drive(t, fl, rs);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction as the held ID/EX register would present it.
  // abort_at (1-based cycle) applies flush or reset in that cycle; 0 = none.
  task automatic run_instr(input instr_t t, input int forced, input int abort_at, input bit abort_rst);
    int last = (t.op == OP_MUL) ? MUL_LEN : 1;
    for (int c = 1; c <= last; c++) begin
      instr_t cur;
      bit ab, st;
      // Past the first cycle the inputs must not matter, so scramble them.
      cur = (c == 1) ? t : rand_instr();
      ab  = (c == abort_at);
      st  = (t.op == OP_MUL) && (c <= MUL_LEN - 1) && !(c == 1 && ab && abort_rst);
      if (ab) begin
        cycle(cur, !abort_rst, abort_rst, bubble(st));
        return;
      end
      cycle(cur, 1'b0, 1'b0, (c == last) ? result_of(t, forced, st) : bubble(st));
    end
  endtask

  // Monitor: every cycle with a scoreboard entry, check stall mid-cycle and
  // the registered EX/MEM fields just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall", bus.stall, e.stall);
        @(posedge clk);
        #2;
        check("MemToReg_out",  bus.MemToReg_out,  e.m2r);
        check("MemRead_out",   bus.MemRead_out,   e.mrd);
        check("MemWrite_out",  bus.MemWrite_out,  e.mwr);
        check("RegWrite_out",  bus.RegWrite_out,  e.rw);
        check("ALUResult_out", bus.ALUResult_out, e.res);
        check("WriteData_out", bus.WriteData_out, e.wd);
        check("RR3_out",       bus.RR3_out,       e.rr3);
        check("pc_out",        bus.pc_out,        e.pc);
        check("zero_out",      bus.zero_out,      e.zero);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    drive(mk(0, 0, 0, 0, 1'b0, 1'b0, 0), 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Reset edges: plain op, then a MUL presented during reset (no stall).
    cycle(mk(0, 0, 0, 0, 1'b0, 1'b0, 0), 1'b0, 1'b1, bubble(1'b0));
    cycle(mk(OP_MUL, 3, 4, 0, 1'b0, 1'b1, 2), 1'b0, 1'b1, bubble(1'b0));

    // Directed cases with literal results.
    run_instr(mk(0, 200, 0, 300, 1'b1, 1'b1, 5), 500, 0, 1'b0);
    run_instr(mk(1, 5, 7, 0, 1'b0, 1'b1, 3), 2097150, 0, 1'b0);
    run_instr(mk(1, 9, 9, 0, 1'b0, 1'b1, 3), 0, 0, 1'b0);
    run_instr(mk(OP_MUL, 1000, 3000, 0, 1'b0, 1'b1, 6), 902848, 0, 1'b0);
    run_instr(mk(OP_MUL, 1234, 5678, 0, 1'b0, 1'b1, 7), -1, 11, 1'b0);  // flush, 10th MUL cycle
    run_instr(mk(0, 1, 0, 1, 1'b1, 1'b1, 1), 2, 0, 1'b0);
    run_instr(mk(OP_MUL, 777, 888, 0, 1'b0, 1'b1, 8), -1, 6, 1'b1);     // reset, 5th MUL cycle
    run_instr(mk(6, 1, 0, 20, 1'b1, 1'b1, 4), 1048576, 0, 1'b0);
    run_instr(mk(6, 1, 0, 25, 1'b1, 1'b1, 4), 0, 0, 1'b0);
    run_instr(mk(7, 21'h100000, 0, 20, 1'b1, 1'b1, 4), 1, 0, 1'b0);
    run_instr(mk(OP_MUL, MASK, MASK, 0, 1'b0, 1'b1, 9), 1, 0, 1'b0);    // (2^21-1)^2 mod 2^21

    // Randomized traffic with occasional flush/reset aborts.
    for (int i = 0; i < 80; i++) begin
      int r, last, ab;
      t    = rand_instr();
      last = (t.op == OP_MUL) ? MUL_LEN : 1;
      r    = int'($urandom_range(0, 19));
      ab   = (r < 2) ? int'($urandom_range(1, last)) : 0;
      run_instr(t, -1, ab, r == 1);
    end

    drive(mk(0, 0, 0, 0, 1'b0, 1'b0, 0), 1'b0, 1'b0);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #3;
    check("scoreboard_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_ex.md
Name: segment_ex

Overview:
- Execute stage of the 5-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs.
- Selects operand B, performs the ALU operation, and registers the result together with the surviving control bits toward the EX/MEM stage.
- Contains an iterative shift-add multiplier. While the multiplier runs, `stall` freezes the upstream stages and bubbles are inserted downstream.

Parameters:
- DATA_WIDTH, 21, datapath width for pc, register data and immediate.
- REG_ADDR_WIDTH, 4, destination register index width.
- MUL_CYCLES, DATA_WIDTH, number of multiplier iterations.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; kills the instruction currently in EX.
- MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in  in  1 each  control bits from ID/EX.
- ALUSrc_in  in  1  selects operand B: 1 = num_in, 0 = RD2_in.
- ALUOp_in  in  3  ALU operation code.
- pc_in  in  DATA_WIDTH  instruction pc.
- RD1_in, RD2_in, RD3_in  in  DATA_WIDTH each  operand A, register B, store data.
- RR3_in  in  REG_ADDR_WIDTH  destination register index.
- num_in  in  DATA_WIDTH  immediate.
- MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out  out  1 each  registered control bits.
- ALUResult_out  out  DATA_WIDTH  registered ALU result.
- WriteData_out  out  DATA_WIDTH  registered RD3_in (store data).
- RR3_out  out  REG_ADDR_WIDTH  registered destination index.
- pc_out  out  DATA_WIDTH  registered pc.
- zero_out  out  1  registered flag, 1 when ALUResult is 0.
- stall  out  1  combinational; 1 means ID/EX and earlier stages must hold.

Behaviour:
- Reset: with rst=1 at an edge, every output register is cleared to 0 and the FSM goes to IDLE. `stall` is 0 while in IDLE with rst=1. rst has priority over flush and over all operations.
- Operand selection: A = RD1_in; B = ALUSrc_in ? num_in : RD2_in.
- ALU operations; all arithmetic is modulo 2^DATA_WIDTH and unsigned:
  - 000 ADD.
  - 001 SUB (A-B, wraps).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MUL (multi-cycle, low DATA_WIDTH bits of the product).
  - 110 SLL, shift amount B[4:0].
  - 111 SRL logical, shift amount B[4:0].
  - For SLL/SRL, any shift amount >= DATA_WIDTH gives 0.
- Single-cycle operations (FSM in IDLE, ALUOp≠101): `stall`=0. On the next edge all outputs load the result and pass-through fields (latency 1 cycle).
- FSM states: IDLE, MUL, DONE.
  - IDLE with ALUOp=101: `stall`=1 combinationally in that cycle. On the edge: latch A, B and all pass-through inputs; clear accumulator and counter; go to MUL. Outputs load a bubble.
  - MUL: `stall`=1. Each edge: if B_shift[0]=1, acc += A_shift; then A_shift <<= 1, B_shift >>= 1, counter += 1. Go to DONE after the edge where counter reaches MUL_CYCLES-1 (21 iterations). Outputs load a bubble on every edge.
  - DONE: `stall`=0; ALUOp_in is ignored, because the same MUL is still held upstream. On the edge: outputs load acc plus the latched control, pc, RD3 and RR3; FSM goes to IDLE.
- MUL timing: `stall` is high for 22 consecutive cycles. The result appears 23 edges after the MUL is first presented.
- Bubble definition: MemToReg/MemRead/MemWrite/RegWrite = 0; ALUResult, WriteData, RR3, pc = 0; zero_out = 0.
- Flush: with flush=1 at an edge, outputs load a bubble and the FSM goes to IDLE from any state, aborting a MUL. `stall` follows the state, so a flush in MUL drops `stall` on the next cycle.
- Inputs are sampled only in IDLE; changes to inputs during MUL/DONE have no effect.
- zero_out is derived from the value being loaded into ALUResult_out, except for bubbles, where it is 0.

Test Plan:
- rst=1 for 1 edge, then ADD with RD1=200, num=300, ALUSrc=1, RegWrite=1, RR3=5 -> after 1 edge: ALUResult=500, RegWrite_out=1, RR3_out=5, zero_out=0, stall=0 throughout.
- SUB with RD1=5, RD2=7, ALUSrc=0 -> ALUResult=2097150 (21'h1FFFFE). SUB with RD1=RD2=9 -> ALUResult=0, zero_out=1.
- MUL with RD1=1000, RD2=3000, RegWrite=1, RR3=6 -> stall=1 for exactly 22 cycles and outputs are bubbles. On the 23rd edge: ALUResult=902848 (3,000,000 mod 2^21), RegWrite_out=1, RR3_out=6.
- MUL started, then flush=1 in the 10th MUL cycle -> next cycle stall=0 with a bubble at the outputs. A following ADD 1+1 yields 2 after 1 edge.
- MUL started, then rst=1 in the 5th MUL cycle -> all outputs 0 and stall=0 the next cycle; changing RD1 mid-reset has no effect.
- SLL with RD1=1, num=20, ALUSrc=1 -> ALUResult=1048576. SLL with num=25 -> 0. SRL with RD1=21'h100000, num=20 -> 1.
